// File: rtl/monolith_axil_ctrl.sv
// AXI4-Lite register front end and start/done sequencer for the Monolith-31 hash core.
// Optional watchdog on the WAIT state is enabled with `define MONOLITH_CTRL_TIMEOUT_EN.
module monolith_axil_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic [30:0]       core_in,
  output logic              core_start,
  input  logic              core_done,
  input  logic [30:0]       core_out,
  output logic              irq,
  output logic [1:0]        dbg_state
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Handshakes: a transfer happens on any rising aclk edge where valid and ready are both
  // high; a valid, once raised, holds its payload until that edge.
  logic              live_q;
  logic              aw_full, w_full;
  logic [ADDR_W-1:2] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic [1:0]        state;
  logic              start_req, abort_q, valid_q, clr_pend_q, irq_pend_q;
  logic              go_q, irq_en_q, timeout_q, timeout_hit;
  logic [30:0]       din_q, result_q;
  logic [31:0]       din_merged;
  logic [30:0]       din_canon;
  logic              busy, wr_fire, wr_bad, rd_bad, din_wr, ctrl_wr, go_rise, go_clr, stat_w1c, latch;
  logic [1:0]        wr_idx;
  logic [31:0]       status, rd_word;
  logic              unused_bits;

  assign busy          = (state != S_IDLE);
  assign s_axi_awready = live_q & ~aw_full & ~s_axi_bvalid;
  assign s_axi_wready  = live_q & ~w_full & ~s_axi_bvalid;
  assign s_axi_arready = live_q & ~s_axi_rvalid;
  assign core_in       = din_q;
  assign core_start    = (state == S_START);
  assign irq           = irq_pend_q & irq_en_q;
  assign dbg_state     = state;
  assign unused_bits   = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], din_merged[31]};

  assign wr_fire  = aw_full & w_full & ~s_axi_bvalid;
  assign wr_bad   = |aw_addr_q[ADDR_W-1:4];
  assign wr_idx   = aw_addr_q[3:2];
  assign din_wr   = wr_fire & ~wr_bad & (wr_idx == 2'd0) & ~busy;
  assign ctrl_wr  = wr_fire & ~wr_bad & (wr_idx == 2'd3) & w_strb_q[0];
  assign go_rise  = ctrl_wr & w_data_q[0] & ~go_q;
  assign go_clr   = ctrl_wr & ~w_data_q[0];
  assign stat_w1c = wr_fire & ~wr_bad & (wr_idx == 2'd1) & w_strb_q[0] & w_data_q[1];
  assign latch    = (state == S_WAIT) & core_done & ~abort_q;

  always_comb begin
    din_merged = {1'b0, din_q};
    for (int i = 0; i < 4; i++)
      if (w_strb_q[i]) din_merged[8*i +: 8] = w_data_q[8*i +: 8];
    // All-ones is the non-canonical encoding of zero in GF(2^31-1).
    din_canon = (din_merged[30:0] == 31'h7FFF_FFFF) ? 31'd0 : din_merged[30:0];
  end

`ifdef MONOLITH_CTRL_TIMEOUT_EN
  logic [31:0] to_cnt;
  assign timeout_hit = (state == S_WAIT) & ~core_done & (to_cnt == 32'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt <= (state == S_WAIT) ? to_cnt + 32'd1 : 32'd0;
      if (timeout_hit)  timeout_q <= 1'b1;
      else if (go_rise) timeout_q <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_q   = 1'b0;
`endif

  assign status = {29'd0, timeout_q, irq_pend_q, busy};
  assign rd_bad = |s_axi_araddr[ADDR_W-1:4];
  always_comb begin
    rd_word = 32'd0;
    case (s_axi_araddr[3:2])
      2'd0:    rd_word = {1'b0, din_q};
      2'd1:    rd_word = status;
      2'd2:    rd_word = {result_q, valid_q};
      default: rd_word = {30'd0, irq_en_q, go_q};
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live_q       <= 1'b0;
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= 2'b00;
    end else begin
      live_q <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_full   <= 1'b1;
        aw_addr_q <= s_axi_awaddr[ADDR_W-1:2];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_full   <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (wr_fire) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= (wr_bad || (wr_idx == 2'd0 && busy)) ? 2'b10 : 2'b00;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_bad ? 32'd0 : rd_word;
        s_axi_rresp  <= rd_bad ? 2'b10 : 2'b00;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      start_req  <= 1'b0;
      abort_q    <= 1'b0;
      valid_q    <= 1'b0;
      clr_pend_q <= 1'b0;
      irq_pend_q <= 1'b0;
      result_q   <= '0;
      din_q      <= '0;
      go_q       <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      start_req  <= go_rise & ~busy;
      clr_pend_q <= go_clr & latch;
      if (din_wr) din_q <= din_canon;
      if (ctrl_wr) begin
        go_q     <= w_data_q[0];
        irq_en_q <= w_data_q[1];
      end
      case (state)
        S_IDLE:  if (start_req) state <= S_START;
        S_START: state <= S_WAIT;
        S_WAIT:  if (core_done) state <= abort_q ? S_IDLE : S_DONE;
                 else if (timeout_hit) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (state != S_WAIT)              abort_q <= 1'b0;
      else if (go_clr && !core_done)    abort_q <= 1'b1;
      // A completion landing with a go=0 write still latches; valid drops a cycle later.
      if (latch) begin
        valid_q  <= 1'b1;
        result_q <= core_out;
      end else if (state == S_START || go_clr || clr_pend_q) begin
        valid_q <= 1'b0;
      end
      if ((latch || timeout_hit) && irq_en_q) irq_pend_q <= 1'b1;
      else if (stat_w1c)                       irq_pend_q <= 1'b0;
    end
  end
endmodule
